// File: rtl/tmr_err_monitor_pkg.sv
// tmr_mon_pkg: shared types and arithmetic helpers for the TMR error monitor.
package tmr_mon_pkg;
    typedef enum logic [1:0] {IDLE, ARMED, ALARM} mon_state_t;

    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] step,
                                            input logic [31:0] max);
        return (max - v < step) ? max : v + step;
    endfunction

    function automatic logic [31:0] popcount(input logic [63:0] v);
        logic [31:0] n;
        n = '0;
        for (int i = 0; i < 64; i++) n += 32'(v[i]);
        return n;
    endfunction
endpackage

// File: rtl/tmr_err_monitor_if.sv
// tmr_err_monitor_if: voter error inputs, clear/select controls and monitor outputs.
interface tmr_err_monitor_if #(
    parameter int N_VOTERS = 8,
    parameter int CNT_W    = 8,
    parameter int TOT_W    = 16
);
    localparam int SEL_W = N_VOTERS > 1 ? $clog2(N_VOTERS) : 1;
    logic [N_VOTERS-1:0] err_i;
    logic                clear_i;
    logic [SEL_W-1:0]    sel_i;
    logic [CNT_W-1:0]    count_o;
    logic [N_VOTERS-1:0] sticky_o;
    logic [N_VOTERS-1:0] persist_o;
    logic [TOT_W-1:0]    total_o;
    logic                alarm_o;
    modport master (output err_i, clear_i, sel_i,
                    input  count_o, sticky_o, persist_o, total_o, alarm_o);
    modport slave  (input  err_i, clear_i, sel_i,
                    output count_o, sticky_o, persist_o, total_o, alarm_o);
endinterface

// File: rtl/tmr_err_monitor_channel.sv
// tmr_err_channel: per-voter edge detect, saturating event count, sticky and persistence flags.
module tmr_err_channel #(
    parameter int CNT_W   = 8,
    parameter int PERSIST = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear_i,
    input  logic             err_i,
    output logic             ev_o,
    output logic [CNT_W-1:0] cnt_o,
    output logic             sticky_o,
    output logic             persist_o
);
    import tmr_mon_pkg::*;
    localparam int RUN_W = $clog2(PERSIST + 1);
    localparam logic [31:0] CNT_MAX = 32'((64'd1 << CNT_W) - 64'd1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(PERSIST);
    logic             err_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sticky_q, sticky_d, persist_q, persist_d;
    logic [RUN_W-1:0] run_q, run_d;
    // err_q survives clear so a held err is not recounted after clearing
    always_comb begin
        ev_o      = err_i & ~err_q;
        cnt_d     = clear_i ? CNT_W'(ev_o) :
                    ev_o    ? CNT_W'(sat_inc(32'(cnt_q), 32'd1, CNT_MAX)) : cnt_q;
        sticky_d  = (sticky_q & ~clear_i) | ev_o;
        run_d     = !err_i            ? '0 :
                    clear_i           ? RUN_W'(1) :
                    run_q == RUN_MAX  ? run_q : run_q + 1'b1;
        persist_d = (persist_q & ~clear_i) | (run_d == RUN_MAX);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q     <= 1'b0;
            cnt_q     <= '0;
            sticky_q  <= 1'b0;
            persist_q <= 1'b0;
            run_q     <= '0;
        end else begin
            err_q     <= err_i;
            cnt_q     <= cnt_d;
            sticky_q  <= sticky_d;
            persist_q <= persist_d;
            run_q     <= run_d;
        end
    end
    assign cnt_o     = cnt_q;
    assign sticky_o  = sticky_q;
    assign persist_o = persist_q;
endmodule

// File: rtl/tmr_err_monitor.sv
// tmr_err_monitor: turns TMR voter disagreement into counts, sticky/persist flags and a burst alarm.
module tmr_err_monitor #(
    parameter int N_VOTERS = 8,
    parameter int CNT_W    = 8,
    parameter int TOT_W    = 16,
    parameter int WINDOW   = 1024,
    parameter int THRESH   = 4,
    parameter int PERSIST  = 16
) (
    input logic               clk,
    input logic               rst,
    tmr_err_monitor_if.slave  bus
);
    import tmr_mon_pkg::*;
    localparam int WC_W = $clog2(WINDOW);
    localparam int WE_W = $clog2(THRESH + N_VOTERS + 1);
    localparam logic [31:0] TOT_MAX = 32'((64'd1 << TOT_W) - 64'd1);
    logic [N_VOTERS-1:0] ev, sticky, persist;
    logic [CNT_W-1:0]    cnt [N_VOTERS];
    logic [31:0]         pop;
    mon_state_t          state_q, state_d, base;
    logic [WC_W-1:0]     win_cnt_q, win_cnt_d;
    logic [WE_W-1:0]     win_ev_q, win_ev_d;
    logic [TOT_W-1:0]    total_q, total_d;
    for (genvar i = 0; i < N_VOTERS; i++) begin : g_ch
        tmr_err_channel #(.CNT_W(CNT_W), .PERSIST(PERSIST)) u_ch (
            .clk(clk), .rst(rst), .clear_i(bus.clear_i), .err_i(bus.err_i[i]),
            .ev_o(ev[i]), .cnt_o(cnt[i]), .sticky_o(sticky[i]), .persist_o(persist[i])
        );
    end
    // clear forces IDLE first, then this cycle's events are applied on top
    always_comb begin
        pop       = popcount(64'(ev));
        base      = bus.clear_i ? IDLE : state_q;
        state_d   = base;
        win_cnt_d = win_cnt_q;
        win_ev_d  = win_ev_q;
        if (base == IDLE) begin
            state_d   = pop >= 32'(THRESH) ? ALARM : pop != 0 ? ARMED : IDLE;
            win_cnt_d = '0;
            win_ev_d  = WE_W'(pop);
        end else if (base == ARMED) begin
            win_cnt_d = win_cnt_q + 1'b1;
            win_ev_d  = WE_W'(32'(win_ev_q) + pop);
            state_d   = 32'(win_ev_q) + pop >= 32'(THRESH) ? ALARM :
                        32'(win_cnt_q) == 32'(WINDOW - 1)  ? IDLE : ARMED;
        end
        total_d = TOT_W'(sat_inc(bus.clear_i ? 32'd0 : 32'(total_q), pop, TOT_MAX));
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            win_cnt_q <= '0;
            win_ev_q  <= '0;
            total_q   <= '0;
        end else begin
            state_q   <= state_d;
            win_cnt_q <= win_cnt_d;
            win_ev_q  <= win_ev_d;
            total_q   <= total_d;
        end
    end
    assign bus.count_o   = cnt[bus.sel_i];
    assign bus.sticky_o  = sticky;
    assign bus.persist_o = persist;
    assign bus.total_o   = total_q;
    assign bus.alarm_o   = state_q == ALARM;
endmodule

// File: tb/tb_tmr_err_monitor.sv
// tb_tmr_err_monitor: randomized and directed stimulus scored against a behavioural model.
module tb_tmr_err_monitor;
    localparam int N = 8, CW = 8, TW = 16, WINDOW = 1024, THRESH = 4, PERSIST = 16;
    localparam int CMAX = 255, TMAX = 65535;
    logic clk = 1'b0, rst = 1'b1;
    always #5 clk = ~clk;
    tmr_err_monitor_if #(.N_VOTERS(N), .CNT_W(CW), .TOT_W(TW)) bus ();
    tmr_err_monitor #(.N_VOTERS(N), .CNT_W(CW), .TOT_W(TW), .WINDOW(WINDOW),
                      .THRESH(THRESH), .PERSIST(PERSIST)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct packed {
        logic [N*CW-1:0] cnts;
        logic [N-1:0]    sticky;
        logic [N-1:0]    persist;
        logic [TW-1:0]   total;
        logic            alarm;
    } exp_t;
    exp_t q[$];
    int checks = 0, errors = 0;

    int m_cnt[N], m_run[N], m_total, m_age, m_wev;
    bit m_prev[N], m_sticky[N], m_pers[N], m_alarm, m_open;

    function automatic void check(string name, logic [63:0] act, logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            if (errors <= 30) $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
        end
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < N; i++) begin
            m_cnt[i] = 0; m_run[i] = 0; m_prev[i] = 0; m_sticky[i] = 0; m_pers[i] = 0;
        end
        m_total = 0; m_age = 0; m_wev = 0; m_alarm = 0; m_open = 0;
    endfunction

    function automatic void model_step(logic [N-1:0] e, bit clr);
        int n = 0;
        if (clr) begin
            for (int i = 0; i < N; i++) begin
                m_cnt[i] = 0; m_sticky[i] = 0; m_pers[i] = 0; m_run[i] = 0;
            end
            m_total = 0; m_alarm = 0; m_open = 0;
        end
        for (int i = 0; i < N; i++) begin
            if (e[i] && !m_prev[i]) begin
                n++;
                m_cnt[i] = m_cnt[i] < CMAX ? m_cnt[i] + 1 : CMAX;
                m_sticky[i] = 1;
            end
            m_prev[i] = e[i];
            m_run[i] = e[i] ? (m_run[i] < PERSIST ? m_run[i] + 1 : PERSIST) : 0;
            if (m_run[i] == PERSIST) m_pers[i] = 1;
        end
        m_total = m_total + n > TMAX ? TMAX : m_total + n;
        if (!m_alarm) begin
            if (m_open) begin
                if (m_wev + n >= THRESH) begin m_alarm = 1; m_open = 0; end
                else if (m_age == WINDOW - 1) m_open = 0;
                else begin m_wev += n; m_age++; end
            end else if (n >= THRESH) m_alarm = 1;
            else if (n > 0) begin m_open = 1; m_age = 0; m_wev = n; end
        end
    endfunction

    function automatic exp_t snapshot();
        exp_t x;
        for (int i = 0; i < N; i++) begin
            x.cnts[i*CW +: CW] = CW'(m_cnt[i]);
            x.sticky[i] = m_sticky[i];
            x.persist[i] = m_pers[i];
        end
        x.total = TW'(m_total);
        x.alarm = m_alarm;
        return x;
    endfunction

    task automatic cyc(logic [N-1:0] e, bit clr = 0);
        bus.err_i = e;
        bus.clear_i = clr;
        bus.sel_i = 3'($urandom_range(N - 1));
        model_step(e, clr);
        @(posedge clk);
        q.push_back(snapshot());
        #1;
    endtask

    task automatic check_zero(string tag);
        check({tag, "_count"}, 64'(bus.count_o), 0);
        check({tag, "_sticky"}, 64'(bus.sticky_o), 0);
        check({tag, "_persist"}, 64'(bus.persist_o), 0);
        check({tag, "_total"}, 64'(bus.total_o), 0);
        check({tag, "_alarm"}, 64'(bus.alarm_o), 0);
    endtask

    always @(negedge clk) begin
        exp_t x;
        if (!rst && q.size() > 0) begin
            x = q.pop_front();
            check("count", 64'(bus.count_o), 64'(x.cnts[int'(bus.sel_i)*CW +: CW]));
            check("sticky", 64'(bus.sticky_o), 64'(x.sticky));
            check("persist", 64'(bus.persist_o), 64'(x.persist));
            check("total", 64'(bus.total_o), 64'(x.total));
            check("alarm", 64'(bus.alarm_o), 64'(x.alarm));
        end
    end

    initial begin
        logic [N-1:0] e;
        int seq[4] = '{0, 1, 2, 0};
        bus.err_i = '0; bus.clear_i = 1'b0; bus.sel_i = '0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_zero("reset");
        repeat (5) cyc(8'h08);
        repeat (3) cyc('0);
        cyc('0, 1);
        foreach (seq[k]) begin
            cyc(8'(1 << seq[k]));
            repeat (3) cyc('0);
        end
        repeat (5) cyc('0);
        cyc('0, 1);
        cyc('0);
        for (int k = 3; k < 6; k++) begin cyc(8'(1 << k)); cyc('0); end
        repeat (WINDOW + 5) cyc('0);
        for (int k = 3; k < 6; k++) begin cyc(8'(1 << k)); cyc('0); end
        cyc('0, 1);
        repeat (PERSIST) cyc(8'h20);
        cyc('0);
        repeat (PERSIST - 1) cyc(8'h40);
        repeat (2) cyc('0);
        cyc('0, 1);
        cyc(8'h04, 1);
        cyc('0);
        cyc('0, 1);
        repeat (260) begin cyc(8'h02); cyc('0); end
        e = '0;
        repeat (3000) begin
            e ^= 8'($urandom & $urandom & $urandom);
            cyc(e, $urandom_range(99) == 0);
        end
        cyc('0, 1);
        cyc(8'h01);
        repeat (3) cyc('0);
        @(negedge clk);
        #2 rst = 1'b1;
        #1 check_zero("async_rst");
        q.delete();
        model_reset();
        bus.err_i = '0; bus.clear_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) cyc('0);
        cyc(8'h10);
        repeat (3) cyc('0);
        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/tmr_err_monitor.md
# tmr_err_monitor

Downstream consumer of the `err` outputs from a bank of TMR majority voters. It turns raw voter disagreement into fault-management state:
- per-voter event counts and sticky flags
- a persistent-fault indication
- a windowed burst alarm

It sits beside the voted datapath in the same clock domain and feeds the scrubbing/reconfiguration controller. Its own state is not triplicated.

## Interface
Parameters:
- `N_VOTERS`, 8, number of voter `err` inputs monitored (≥1)
- `CNT_W`, 8, width of each per-voter saturating event counter
- `TOT_W`, 16, width of the global saturating event counter
- `WINDOW`, 1024, burst window length in cycles (≥2)
- `THRESH`, 4, events within one window that raise `alarm_o` (1..WINDOW)
- `PERSIST`, 16, consecutive cycles of `err` high that mark a voter persistent (≥2)

Ports:
- `clk`  in  1  sole clock; `err_i` is synchronous to it
- `rst`  in  1  asynchronous, active-high reset
- `err_i`  in  N_VOTERS  voter `err` signals, bit i from voter i
- `clear_i`  in  1  single-cycle pulse; clears all monitor state
- `sel_i`  in  $clog2(N_VOTERS) (min 1)  voter index for `count_o`
- `count_o`  out  CNT_W  event count of voter `sel_i` (combinational mux of registered counters)
- `sticky_o`  out  N_VOTERS  bit i set once voter i has flagged any event
- `persist_o`  out  N_VOTERS  bit i set once voter i has held `err` for PERSIST cycles
- `total_o`  out  TOT_W  saturating sum of all events
- `alarm_o`  out  1  burst alarm, latched

## Operation
Events:
- Event on voter i means a rising edge: `err_i[i] & ~err_q[i]`, where `err_q` is `err_i` registered.
- A held-high `err` is therefore one event, not one event per cycle.

Per-voter counters:
- Increment by 1 per event and saturate at 2^CNT_W-1.
- The sticky bit sets on the first event.

Persistence:
- A per-voter run counter increments while `err_i[i]` is 1 and resets to 0 when it is 0.
- When the run reaches PERSIST, `persist_o[i]` sets and latches.

Global counter:
- `total_o` adds the popcount of the events in a cycle, saturating at 2^TOT_W-1.

Burst FSM (`IDLE`, `ARMED`, `ALARM`); `win_cnt` counts cycles, `win_ev` counts events in the current window:
- IDLE → ARMED on a cycle with any event. `win_cnt`←0, `win_ev`←popcount.
- ARMED: `win_cnt`++ and `win_ev` += popcount each cycle.
  - If `win_ev`+popcount ≥ THRESH → ALARM.
  - Else, if `win_cnt` = WINDOW-1 → IDLE.
  - Threshold takes priority over expiry in the same cycle.
- IDLE, when popcount ≥ THRESH in a single cycle: go directly to ALARM.
- ALARM: hold until `clear_i`. `alarm_o` = (state == ALARM).

Clear:
- `clear_i` zeroes all counters, sticky bits, persist bits and `total_o`, and forces the FSM to IDLE.
- An event in the same cycle as `clear_i` is applied after the clear. Example: voter 2 rises during clear → count[2]=1, sticky[2]=1, FSM=ARMED.
- A persistence run in progress restarts from 1 if `err_i` is still high.

Reset:
- All outputs and state go to 0 and the FSM to IDLE.
- `err_q` resets to 0, so an `err_i` that is high at reset release counts as one event.

## Timing
- Event at input in cycle t → `count_o`, `sticky_o`, `total_o` updated after edge t+1.
- Edge detection registers `err_i` but does not delay the event.
- `alarm_o` asserts one cycle after the threshold-crossing event is sampled.
- `persist_o[i]` asserts after the PERSIST-th consecutive high cycle.
- `clear_i` takes effect at the next edge; outputs show the cleared values the following cycle.
- `count_o` follows `sel_i` combinationally in the same cycle.
- No backpressure and no handshake beyond the `clear_i` pulse.

## Structure
- Package `tmr_mon_pkg`:
  - `mon_state_t` enum (IDLE, ARMED, ALARM)
  - a saturating-increment function
  - a popcount function
- Sub-module `tmr_err_channel`, instantiated N_VOTERS times. Each instance holds:
  - edge detect
  - saturating counter
  - sticky bit
  - persistence run counter and flag
  - event output
- The top level holds the popcount, global counter, burst FSM and `count_o` mux.

## Test plan
- Reset with `err_i`=0 → all outputs 0. Pulse `err_i[3]` high for 5 cycles → count[3]=1, sticky=8'h08, total=1, persist=0, no alarm (THRESH=4).
- Four separate 1-cycle pulses on voters 0,1,2,0 within 100 cycles → `alarm_o`=1 one cycle after the 4th pulse; count[0]=2; `alarm_o` holds until `clear_i`, then all outputs are 0.
- 3 events, then a gap of WINDOW cycles, then 3 events → no alarm; FSM returns to IDLE between bursts; total=6.
- Hold `err_i[5]` high for PERSIST cycles → `persist_o[5]`=1 exactly after the 16th cycle. Holding 15 cycles then dropping → no flag.
- With CNT_W=2, 5 pulses on voter 1 → count[1] saturates at 3; total=5.
- `clear_i` in the same cycle as rising `err_i[2]` → count[2]=1, sticky=8'h04, total=1. Also assert `rst` mid-window → all outputs 0 immediately (asynchronous).
